// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC channel averager.
// Alarm state encoding and accumulator width helper.
package adc_pkg;

  localparam int ADC_DATA_W = 12;
  localparam int ADC_CH_W   = 3;
  localparam int ADC_MAX_CH = 8;

  typedef enum logic {
    NORMAL = 1'b0,
    ALARM  = 1'b1
  } alarm_t;

  // Summing 2^l2 samples of dw bits needs dw+l2 bits.
  function automatic int acc_w(input int dw, input int l2);
    return dw + l2;
  endfunction

endpackage

// File: rtl/adc_chan_accum.sv
// One channel: boxcar accumulator, stored average and
// hysteresis alarm FSM.
module adc_chan_accum
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 3
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              hit,
  input  logic [DATA_W-1:0] data,
  input  logic              clr,
  input  logic [DATA_W-1:0] thr_hi,
  input  logic [DATA_W-1:0] thr_lo,
  output logic [DATA_W-1:0] avg,
  output logic              done,
  output logic              avg_vld,
  output logic              alarm,
  output logic              alarm_rise
);

  localparam int ACC_W = acc_w(DATA_W, AVG_LOG2);
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  alarm_t           state;
  alarm_t           state_nx;

  assign sum   = acc + ACC_W'(data);
  assign alarm = (state == ALARM);

  // Accumulate; on the last sample publish the average.
  always_ff @(posedge iCLK) begin
    if (!iRST || clr) begin
      acc     <= '0;
      cnt     <= '0;
      avg     <= '0;
      avg_vld <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (hit) begin
        if (cnt == CNT_LAST) begin
          avg     <= DATA_W'(sum >> AVG_LOG2);
          acc     <= '0;
          cnt     <= '0;
          avg_vld <= 1'b1;
          done    <= 1'b1;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // Alarm next state; done marks a fresh avg to evaluate.
  always_comb begin
    state_nx   = state;
    alarm_rise = 1'b0;
    if (done && !clr) begin
      unique case (state)
        NORMAL: begin
          if (avg > thr_hi) begin
            state_nx   = ALARM;
            alarm_rise = 1'b1;
          end
        end
        ALARM: begin
          if (avg < thr_lo) state_nx = NORMAL;
        end
        default: state_nx = NORMAL;
      endcase
    end
  end

  // Alarm state register.
  always_ff @(posedge iCLK) begin
    if (!iRST || clr) state <= NORMAL;
    else              state <= state_nx;
  end

endmodule

// File: rtl/adc_chan_avg.sv
// Per-channel boxcar averager with register read port,
// done tagging and sticky high-level alarm interrupt.
module adc_chan_avg
  import adc_pkg::*;
#(
  parameter int NUM_CH   = ADC_MAX_CH,
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 3
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iVALID,
  input  logic [2:0]          iCH,
  input  logic [DATA_W-1:0]   iDATA,
  input  logic                iCLR,
  input  logic [DATA_W-1:0]   iTHR_HI,
  input  logic [DATA_W-1:0]   iTHR_LO,
  input  logic [2:0]          iRD_CH,
  output logic [DATA_W-1:0]   oRD_DATA,
  output logic [NUM_CH-1:0]   oAVG_VLD,
  output logic                oDONE,
  output logic [2:0]          oDONE_CH,
  output logic [NUM_CH-1:0]   oALARM,
  output logic                oIRQ,
  input  logic                iIRQ_CLR
);

  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] done;
  logic [NUM_CH-1:0] rise;
  logic [DATA_W-1:0] avg [NUM_CH];
  logic [DATA_W-1:0] rd_sel;
  logic [2:0]        done_ch;

  // Channel decode; tags at or above NUM_CH match nothing.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = iVALID && (iCH == ADC_CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    adc_chan_accum #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_ch (
      .iCLK       (iCLK),
      .iRST       (iRST),
      .hit        (hit[g]),
      .data       (iDATA),
      .clr        (iCLR),
      .thr_hi     (iTHR_HI),
      .thr_lo     (iTHR_LO),
      .avg        (avg[g]),
      .done       (done[g]),
      .avg_vld    (oAVG_VLD[g]),
      .alarm      (oALARM[g]),
      .alarm_rise (rise[g])
    );
  end

  // At most one channel completes per cycle; encode it.
  always_comb begin
    done_ch = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (done[i]) done_ch = ADC_CH_W'(i);
    end
  end

  assign oDONE    = |done;
  assign oDONE_CH = done_ch;

  // Read mux; out-of-range channels read as zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (iRD_CH == ADC_CH_W'(i)) rd_sel = avg[i];
    end
  end

  // Registered read data.
  always_ff @(posedge iCLK) begin
    if (!iRST) oRD_DATA <= '0;
    else       oRD_DATA <= rd_sel;
  end

  // Sticky IRQ; a new alarm beats a coincident clear.
  always_ff @(posedge iCLK) begin
    if (!iRST || iCLR) oIRQ <= 1'b0;
    else if (|rise)    oIRQ <= 1'b1;
    else if (iIRQ_CLR) oIRQ <= 1'b0;
  end

endmodule
